// File: rtl/noc_link_pipe_pkg.sv
// Shared types and constants for the registered NoC link pipe.
package noc_link_pipe_pkg;

    localparam int VC_NUM          = 4;
    localparam int VC_W            = 2;
    localparam int DATA_W          = 16;
    localparam int LINK_MAX_STAGES = 4;
    localparam int LINK_CNT_W      = 32;

    typedef struct packed {
        logic [VC_W-1:0]   vc;
        logic [DATA_W-1:0] data;
    } flit_t;

    // Occupancy counts 0..2*stages; a zero-stage link still needs a 1-bit port.
    function automatic int occ_width(input int stages);
        return (stages == 0) ? 1 : $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/noc_link_pipe_skid_stage.sv
// One full-throughput elastic stage: main register plus skid register.
// in_ready_o comes straight from a flop, so no ready path crosses the stage.
module noc_skid_stage #(
    parameter type flit_t = noc_link_pipe_pkg::flit_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  flit_t      in_flit_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output flit_t      out_flit_o,
    output logic [1:0] occ_o
);

    logic  main_v_q, main_v_d;
    logic  skid_v_q, skid_v_d;
    flit_t main_q, main_d;
    flit_t skid_q, skid_d;
    logic  accept;
    logic  drain;

    assign in_ready_o  = !skid_v_q;
    assign out_valid_o = main_v_q;
    assign out_flit_o  = main_q;
    assign occ_o       = {1'b0, main_v_q} + {1'b0, skid_v_q};

    // Next-state: a drain promotes skid into main; an accept fills main if it
    // is free or freeing this cycle, otherwise parks the flit in skid.
    always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        accept   = in_valid_i && !skid_v_q;
        drain    = main_v_q && out_ready_i;
        if (drain) begin
            main_v_d = skid_v_q;
            main_d   = skid_q;
            skid_v_d = 1'b0;
        end
        if (accept) begin
            if (!main_v_q || drain) begin
                main_v_d = 1'b1;
                main_d   = in_flit_i;
            end else begin
                skid_v_d = 1'b1;
                skid_d   = in_flit_i;
            end
        end
    end

    // Stage registers; flit contents cleared on reset only for tidy waveforms.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

endmodule

// File: rtl/noc_link_pipe.sv
// Registered NoC link: STAGES skid stages on the flit path, a matching
// STAGES-deep shift register on the per-VC ready path, and link statistics.
// STAGES is expected in 0..LINK_MAX_STAGES; 0 wires everything straight through.
module noc_link_pipe
    import noc_link_pipe_pkg::*;
#(
    parameter int  STAGES = 1,
    parameter int  CNT_W  = LINK_CNT_W,
    localparam int OCC_W  = occ_width(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  flit_t             rx_flit_i,
    output logic              rx_ready_o,
    output logic [VC_NUM-1:0] rx_vc_ready_o,
    output logic              tx_valid_o,
    output flit_t             tx_flit_o,
    input  logic              tx_ready_i,
    input  logic [VC_NUM-1:0] tx_vc_ready_i,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  flit_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [OCC_W-1:0]  occupancy_o
);

    // Index k is the input of stage k; index STAGES is the link output.
    logic [STAGES:0] stg_valid;
    logic [STAGES:0] stg_ready;
    flit_t           stg_flit [STAGES+1];

    assign stg_valid[0]      = rx_valid_i;
    assign stg_flit[0]       = rx_flit_i;
    assign rx_ready_o        = stg_ready[0];
    assign tx_valid_o        = stg_valid[STAGES];
    assign tx_flit_o         = stg_flit[STAGES];
    assign stg_ready[STAGES] = tx_ready_i;

    if (STAGES > 0) begin : g_pipe
        logic [1:0]        stg_occ [STAGES];
        logic [VC_NUM-1:0] vc_q    [STAGES];

        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            noc_skid_stage #(.flit_t(flit_t)) u_stage (
                .clk         (clk),
                .rst         (rst),
                .in_valid_i  (stg_valid[k]),
                .in_ready_o  (stg_ready[k]),
                .in_flit_i   (stg_flit[k]),
                .out_valid_o (stg_valid[k+1]),
                .out_ready_i (stg_ready[k+1]),
                .out_flit_o  (stg_flit[k+1]),
                .occ_o       (stg_occ[k])
            );
        end

        // Total flits held is the sum of per-stage occupancy.
        always_comb begin
            occupancy_o = '0;
            for (int k = 0; k < STAGES; k++) begin
                occupancy_o = occupancy_o + OCC_W'(stg_occ[k]);
            end
        end

        // vc_ready delay line; clears to "no VC ready" so upstream waits after reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < STAGES; k++) begin
                    vc_q[k] <= '0;
                end
            end else begin
                vc_q[0] <= tx_vc_ready_i;
                for (int k = 1; k < STAGES; k++) begin
                    vc_q[k] <= vc_q[k-1];
                end
            end
        end

        assign rx_vc_ready_o = vc_q[STAGES-1];
    end else begin : g_bypass
        assign occupancy_o   = '0;
        assign rx_vc_ready_o = tx_vc_ready_i;
    end

    logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counter next-state: clear wins over increment; both wrap naturally.
    always_comb begin
        flit_cnt_d  = flit_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr_i) begin
            flit_cnt_d  = '0;
            stall_cnt_d = '0;
        end else begin
            if (tx_valid_o && tx_ready_i) begin
                flit_cnt_d = flit_cnt_q + CNT_W'(1);
            end
            if (tx_valid_o && !tx_ready_i) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            flit_cnt_q  <= flit_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign flit_cnt_o  = flit_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/noc_link_pipe.md
# noc_link_pipe

Parametrised pipelined link between two `Noc_flit_interface` ports, replacing the plain combinational router-to-router connection when wire length or timing closure requires registered hops. It inserts `STAGES` full-throughput elastic stages (skid buffers) on the forward flit path, with matching register delay on the backward per-VC `vc_ready` path. It also keeps link statistics counters for performance monitoring. It sits between a router output port and the neighbouring router input port, or between a network interface and its router.

## Interface
- `STAGES`, 1, number of elastic stages, legal 0..4; 0 = pure combinational pass-through.
- `CNT_W`, 32, width of statistics counters.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `receiver_if`  Noc_flit_interface.receiver  —  upstream side: `valid`, `flit` in; `ready`, `vc_ready[VC_NUM]` out.
- `sender_if`  Noc_flit_interface.sender  —  downstream side: `valid`, `flit` out; `ready`, `vc_ready[VC_NUM]` in.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `flit_cnt`  out  CNT_W  flits delivered on `sender_if` (`valid && ready`), wraps modulo 2^CNT_W.
- `stall_cnt`  out  CNT_W  cycles with `sender_if.valid && !sender_if.ready`, wraps.
- `occupancy`  out  $clog2(2*STAGES+1)  flits currently held in the pipe (0 when STAGES=0).

## Operation
- **Forward path:**
  - Stage k feeds stage k+1.
  - Stage 0 input is `receiver_if`; stage STAGES-1 output is `sender_if`.
  - Each stage holds a main register and a skid register.
- **Stage rules:**
  - `in_ready = !skid_valid`, registered, so there is no combinational ready path across the stage.
  - Accept when `in_valid && in_ready`.
  - If the main register is empty, or is draining this cycle, the incoming flit goes to main. Otherwise it goes to skid.
  - When main drains (`out_valid && out_ready`) and skid holds a flit, skid moves to main and skid clears in the same edge.
  - A simultaneous accept and drain with skid empty is a pass-through: main is replaced and occupancy is unchanged.
- **Ordering:** flits leave in arrival order; no flit is dropped or duplicated. The flit payload is not inspected or modified.
- **Backward path:** `receiver_if.vc_ready` equals `sender_if.vc_ready` delayed by STAGES register stages. Per-VC bits are independent. Downstream buffers must reserve STAGES×2 extra slots per VC; this is a system requirement and is not checked here.
- **STAGES=0:**
  - All four signals are wired through combinationally.
  - `occupancy` is 0.
  - Counters still operate on `sender_if`.
- **Counters:**
  - `cnt_clr` takes priority over increment in the same cycle.
  - Counters wrap silently at all-ones to 0.
- **Reset:** all stage valid bits are 0. Flit registers are don't-care but are reset to 0 for simulation cleanliness. Reset values of outputs:
  - `receiver_if.ready` is 1 from the first cycle after reset.
  - `sender_if.valid` = 0.
  - `vc_ready` pipeline = 0, so upstream sees no VC ready for STAGES cycles after reset.
  - Counters = 0.
  - `occupancy` = 0.
- **Reset mid-operation:** in-flight flits are discarded. Upstream must treat reset as a link flush.

## Timing
- Forward latency is exactly STAGES cycles from accept on `receiver_if` to `valid` on `sender_if` when downstream is ready.
- Throughput is 1 flit/cycle under continuous `ready`.
- After downstream deasserts `ready`:
  - Each stage absorbs at most 1 extra flit into skid.
  - `receiver_if.ready` falls STAGES cycles later at the latest, since each stage's registered ready propagates one cycle per stage.
- After downstream re-asserts `ready`, the first flit is delivered in the same cycle; there is no bubble.
- `vc_ready` latency is exactly STAGES cycles, with no gating by flit flow.
- Full condition: `occupancy == 2*STAGES` forces `receiver_if.ready = 0`.

## Structure
- New sub-module `noc_skid_stage`:
  - Parametrised on the flit type.
  - Ports `clk`, `rst`, `in_valid/in_ready/in_flit`, `out_valid/out_ready/out_flit`, `occ[1:0]`.
  - Instantiated STAGES times in a generate loop.
- The flit type and `VC_NUM` come from `Noc_parameters`.
- Add to `Noc_parameters`:
  - `LINK_MAX_STAGES = 4`.
  - `LINK_CNT_W = 32` as the default for `CNT_W`.
- The `vc_ready` delay line is a simple generate-loop shift register in the top module.

## Test plan
- **Streaming:** STAGES=2, 10 back-to-back flits with payload 0..9, downstream always ready → flit 0 appears at cycle 2 after first accept, one flit per cycle, `flit_cnt`=10, `stall_cnt`=0.
- **Backpressure:** STAGES=3, downstream ready low for 8 cycles during continuous upstream valid → exactly 6 flits buffered, `receiver_if.ready`=0, `occupancy`=6, `stall_cnt`=8; release → order preserved, no loss.
- **Random handshake:** STAGES=1, random valid/ready at 50% for 1000 cycles with scoreboard → output sequence equals input sequence, and `occupancy` always equals accepted minus delivered.
- **vc_ready delay:** STAGES=4, toggle `sender_if.vc_ready`=4'b1010 for one cycle → `receiver_if.vc_ready` shows 4'b1010 exactly 4 cycles later for one cycle.
- **Reset mid-stream:** STAGES=2 with 4 flits buffered, assert `rst` for 1 cycle → `sender_if.valid`=0, `occupancy`=0, counters=0, `vc_ready`=0, and `ready`=1 next cycle.
- **Counter edge cases:** STAGES=0 → pass-through with zero latency, and `cnt_clr` coinciding with a delivery leaves `flit_cnt`=0. Separately, `CNT_W`=4 with 17 deliveries gives `flit_cnt`=1.
